// File: rtl/lzd_norm_pkg.sv
// Shared types and constants for the sequential leading-zero counter / normalizer.
package lzd_norm_pkg;
  localparam int LZD_WIDTH  = 32;
  localparam int LZD_SLICE  = 8;
  localparam int LZD_NSLICE = 4;
  localparam int LZD_CNT_W  = 6;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} lzd_state_t;

  typedef struct packed {
    logic [LZD_CNT_W-1:0] lz_count;
    logic                 zero;
  } lzd_res_t;
endpackage

// File: rtl/lzd_norm_seq_lzd8b.sv
// 8-bit leading-zero detector: z8 = number of leading zeros, 8 when the byte is all zero.
module lzd8b (
  input  logic [7:0] i8,
  output logic [3:0] z8
);
  always_comb begin
    z8 = 4'd8;
    // Ascending scan: the highest set bit is written last and wins.
    for (int i = 0; i < 8; i++) begin
      if (i8[i]) z8 = 4'(7 - i);
    end
  end
endmodule

// File: rtl/lzd_norm_seq.sv
// Sequential 32-bit leading-zero counter; one lzd8b time-shared over bytes MSB first.
// LZD_NORM_SHIFT_EN adds a SHIFT state and the norm_out port (word << lz_count).
module lzd_norm_seq
  import lzd_norm_pkg::*;
#(
  parameter int WIDTH = LZD_WIDTH,
  parameter int SLICE = LZD_SLICE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     data_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LZD_CNT_W-1:0] lz_count,
  output logic                 zero
`ifdef LZD_NORM_SHIFT_EN
  ,output logic [WIDTH-1:0]    norm_out
`endif
);
  lzd_state_t           state_q, state_d;
  logic [WIDTH-1:0]     word_q, word_d;
  logic [1:0]           idx_q, idx_d;
  logic [LZD_CNT_W-1:0] acc_q, acc_d;
  lzd_res_t             res_q, res_d;
  logic [SLICE-1:0]     byte_sel;
  logic [3:0]           z8;
`ifdef LZD_NORM_SHIFT_EN
  logic [WIDTH-1:0]     norm_q, norm_d;
  localparam lzd_state_t EXIT_ST = SHIFT;
`else
  localparam lzd_state_t EXIT_ST = DONE;
`endif

  assign byte_sel = word_q[{idx_q, 3'b000} +: SLICE];

  lzd8b u_lzd8b (.i8(byte_sel), .z8(z8));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    res_d   = res_q;
`ifdef LZD_NORM_SHIFT_EN
    norm_d  = norm_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        word_d  = data_in;
        idx_d   = 2'd3;
        acc_d   = '0;
        state_d = SCAN;
      end
      SCAN: if (z8[3]) begin
        if (idx_q != 2'd0) begin
          acc_d = acc_q + 6'd8;
          idx_d = idx_q - 2'd1;
        end else begin
          res_d   = '{lz_count: 6'd32, zero: 1'b1};
          state_d = EXIT_ST;
        end
      end else begin
        res_d   = '{lz_count: acc_q + {2'b00, z8}, zero: 1'b0};
        state_d = EXIT_ST;
      end
`ifdef LZD_NORM_SHIFT_EN
      SHIFT: begin
        // A count of 32 pushes every bit out; the 5-bit shift alone would not.
        norm_d  = res_q.lz_count[5] ? '0 : (word_q << res_q.lz_count[4:0]);
        state_d = DONE;
      end
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= 2'd3;
      acc_q   <= '0;
      res_q   <= '0;
`ifdef LZD_NORM_SHIFT_EN
      norm_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
`ifdef LZD_NORM_SHIFT_EN
      norm_q  <= norm_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign lz_count  = res_q.lz_count;
  assign zero      = res_q.zero;
`ifdef LZD_NORM_SHIFT_EN
  assign norm_out  = norm_q;
`endif
endmodule

// File: doc/lzd_norm_seq.md
# lzd_norm_seq

Sequential 32-bit leading-zero counter and normalizer. It time-shares one 8-bit leading-zero detector across the four byte slices of an input word, scanning from the most significant byte down. It returns the leading-zero count and, optionally, the left-normalized word. It sits between an operand source and a downstream normalization/rounding stage, with valid/ready handshakes on both sides.

## Interface
Parameters:
- `WIDTH`, 32: input word width; fixed at 32, i.e. four 8-bit slices.
- `SLICE`, 8: slice width scanned per cycle; fixed at 8.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block can accept a word.
- `data_in`  in  32  word to scan.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `lz_count`  out  6  leading-zero count, 0..32.
- `zero`  out  1  input word was all zero.
- `norm_out`  out  32  `data_in << lz_count`; present only with `LZD_NORM_SHIFT_EN`.

## Operation
- States: IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `data_in` into `word_q`, set `idx`=3, clear `acc`, go to SCAN.
- SCAN:
  - Drive byte `word_q[8*idx+7 : 8*idx]` into the detector and read its result `z` (0..8).
  - If `z`==8 and `idx`≠0: `acc += 8`, `idx -= 1`, stay in SCAN.
  - If `z`<8: `lz_count` = `acc + z`, `zero`=0, exit SCAN.
  - If `z`==8 and `idx`==0: `lz_count`=32, `zero`=1, exit SCAN.
  - Exit target: SHIFT if `LZD_NORM_SHIFT_EN` is defined, else DONE.
- SHIFT: `norm_out` = `word_q << lz_count`; when `lz_count`=32, `norm_out`=0. Go to DONE.
- DONE:
  - `out_valid`=1; outputs stay stable until `out_ready`.
  - On `out_valid & out_ready`: go to IDLE, `out_valid`=0.
- Arithmetic:
  - `acc` is 6 bits, max 24 before the final add; no overflow.
  - Shift amount is 6 bits and saturates to an all-zero result at 32.
- No pipelining: only one word in flight. `in_ready`=0 in every state except IDLE.
- Reset in any state:
  - Next state is IDLE; any in-flight word is discarded.
  - `out_valid`=0, `in_ready`=1 from the cycle after reset.
  - `lz_count`=0, `zero`=0, `norm_out`=0, `acc`=0, `idx`=3.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `lz_count`=0, `zero`=0, `norm_out`=0.
- Accept at edge N. SCAN occupies cycles N+1 .. N+k, where k = 1 + (number of leading all-zero bytes), capped at 4.
- With shift: SHIFT at N+k+1; `out_valid` rises after edge N+k+1 and is first sampled at edge N+k+2.
- Without shift: `out_valid` is first sampled at edge N+k+1.
- Latency from accept to first valid sample:
  - With shift: k+2 edges, range 3..6.
  - Without shift: k+1 edges, range 2..5.
- `out_ready` held high: the DONE→IDLE handshake costs one cycle. The next word is accepted no earlier than one edge after the output handshake.
- `in_valid` while busy is ignored (not captured). The source must hold the word until it sees `in_ready`.

## Configuration
- `LZD_NORM_SHIFT_EN` defined:
  - SHIFT state and a 32-bit barrel shifter are built.
  - `norm_out` is a port.
- Not defined:
  - No SHIFT state and no `norm_out` port; SCAN goes directly to DONE.
  - Latency is one cycle shorter.

## Structure
- Package `lzd_norm_pkg`:
  - State enum `lzd_state_t` {IDLE, SCAN, SHIFT, DONE}.
  - Constants `LZD_WIDTH`=32, `LZD_SLICE`=8, `LZD_NSLICE`=4, `LZD_CNT_W`=6.
- One sub-module: the team's 8-bit leading-zero detector `lzd8b` (input `i8[7:0]`, output `z8[3:0]`, 8 = all-zero), instantiated once and fed by the byte mux.
- Top holds the FSM, `word_q`, `idx`, `acc`, output registers, and the optional shifter.

## Test plan
- Reset check: hold `rst` 2 cycles → `in_ready`=1, `out_valid`=0, `lz_count`=0, `zero`=0.
- Word 0x8000_0000, with shift → `lz_count`=0, `zero`=0, `norm_out`=0x8000_0000. `out_valid` first sampled 3 edges after accept.
- Word 0x0000_0F00 → `lz_count`=20, `norm_out`=0xF000_0000. Latency 5 edges with shift, 4 edges without.
- Word 0x0000_0000 → `lz_count`=32, `zero`=1, `norm_out`=0. Latency 6 edges.
- Backpressure: word 0x0001_0000 with `out_ready`=0 for 5 cycles → `lz_count`=15 stays stable and `in_ready` stays 0. Release `out_ready` → handshake, then `in_ready`=1.
- Mid-scan reset: accept 0x0000_0001, assert `rst` on the 2nd SCAN cycle → no `out_valid`, all outputs 0. The next word 0x4000_0000 returns `lz_count`=1.
